// File: rtl/mux16_pkg.sv
// Shared constants, state encoding and index helpers for the 16-bit serializer.
package mux16_pkg;

  localparam int WIDTH = 16;
  localparam int SEL_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // First select index of a word: bit 0 for LSB-first, bit 15 for MSB-first.
  function automatic logic [SEL_W-1:0] start_idx(input bit msb_first);
    return msb_first ? SEL_W'(WIDTH - 1) : '0;
  endfunction

  // Final select index of a word; the beat at this index carries last.
  function automatic logic [SEL_W-1:0] term_idx(input bit msb_first);
    return msb_first ? '0 : SEL_W'(WIDTH - 1);
  endfunction

endpackage

// File: rtl/mux16x1_structural.sv
// 16:1 bit-select mux built as a four-level tree of 2:1 muxes.
module mux16x1_structural (
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        out
);

  logic [7:0] lvl1;
  logic [3:0] lvl2;
  logic [1:0] lvl3;

  // Level 1: choose within each pair using sel[0].
  for (genvar i = 0; i < 8; i++) begin : g_lvl1
    assign lvl1[i] = sel[0] ? in[2*i+1] : in[2*i];
  end

  // Level 2: choose within each quad using sel[1].
  for (genvar i = 0; i < 4; i++) begin : g_lvl2
    assign lvl2[i] = sel[1] ? lvl1[2*i+1] : lvl1[2*i];
  end

  // Level 3: choose within each octet using sel[2].
  for (genvar i = 0; i < 2; i++) begin : g_lvl3
    assign lvl3[i] = sel[2] ? lvl2[2*i+1] : lvl2[2*i];
  end

  assign out = sel[3] ? lvl3[1] : lvl3[0];

endmodule

// File: rtl/mux16_serializer.sv
// Parallel-in, serial-out stage: captures a 16-bit word on a load handshake
// and walks the embedded 16:1 mux select across it, one bit per output beat.
module mux16_serializer
  import mux16_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [SEL_W-1:0] sel,
  output logic             out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             last,
  output logic             busy
);

  localparam logic [SEL_W-1:0] START = start_idx(MSB_FIRST);
  localparam logic [SEL_W-1:0] TERM  = term_idx(MSB_FIRST);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;

  logic beat_fire;
  logic load_fire;

  // Handshake decode; load_ready is combinational from out_ready so a new
  // word can be taken on the same edge that retires the previous last beat.
  always_comb begin
    out_valid  = (state_q == SHIFT);
    busy       = (state_q == SHIFT);
    last       = (state_q == SHIFT) && (sel_q == TERM);
    load_ready = rst_n && ((state_q == IDLE) || (last && out_ready));
    beat_fire  = out_valid && out_ready;
    load_fire  = load_valid && load_ready;
  end

  // Next-state logic for the FSM, select counter and shadow word.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    if (load_fire) begin
      shadow_d = in;
      sel_d    = START;
      state_d  = SHIFT;
    end else if (beat_fire) begin
      if (last) begin
        state_d = IDLE;
      end else begin
        sel_d = MSB_FIRST ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
      end
    end
  end

  // State registers with synchronous active-low reset; a reset mid-word
  // discards the partial word immediately.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      // NOTE: the shadow word is reset too, so out reads 0 after reset
      // instead of whatever the register powered up with.
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
    end
  end

  assign sel = sel_q;

  mux16x1_structural u_mux (
    .in  (shadow_q),
    .sel (sel_q),
    .out (out)
  );

endmodule

// File: tb/tb_mux16_serializer.sv
// Scoreboard bench: the driver pushes hand-written beat patterns when it loads
// a word, and per-instance monitors pop and compare every fired output beat.
module tb_mux16_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] word = 16'h0000;

  logic        lv_l = 1'b0, rdy_l = 1'b1;
  logic        lr_l, out_l, ov_l, last_l, busy_l;
  logic [3:0]  sel_l;

  logic        lv_m = 1'b0, rdy_m = 1'b1;
  logic        lr_m, out_m, ov_m, last_m, busy_m;
  logic [3:0]  sel_m;

  typedef struct packed {
    logic       bit_v;
    logic [3:0] sel_v;
    logic       last_v;
  } beat_t;

  beat_t q_l[$];
  beat_t q_m[$];

  int n_checks = 0;
  int n_pass   = 0;
  int beats_l  = 0;
  int beats_m  = 0;

  always #5 clk = ~clk;

  mux16_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in(word), .load_valid(lv_l), .load_ready(lr_l),
    .sel(sel_l), .out(out_l), .out_valid(ov_l), .out_ready(rdy_l),
    .last(last_l), .busy(busy_l)
  );

  mux16_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in(word), .load_valid(lv_m), .load_ready(lr_m),
    .sel(sel_m), .out(out_m), .out_valid(ov_m), .out_ready(rdy_m),
    .last(last_m), .busy(busy_m)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // beats: bit k is the expected serial bit on beat k (hand-derived).
  task automatic push_beats(input logic [15:0] beats, input bit msb);
    beat_t b;
    for (int k = 0; k < 16; k++) begin
      b.bit_v  = beats[k];
      b.sel_v  = msb ? 4'(15 - k) : 4'(k);
      b.last_v = (k == 15);
      if (msb) q_m.push_back(b);
      else     q_l.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input bit msb, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (msb) done = !busy_m && (q_m.size() == 0);
      else     done = !busy_l && (q_l.size() == 0);
      if (done) break;
      tick();
    end
    if (!done) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_sel(input logic [3:0] target, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy_l && sel_l == target) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    if (!hit) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Monitor for the LSB-first instance.
  always @(negedge clk) begin
    if (rst_n && ov_l && rdy_l) begin
      beat_t e;
      if (q_l.size() == 0) begin
        check("lsb_unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = q_l.pop_front();
        check("lsb_out",  32'(out_l),  32'(e.bit_v));
        check("lsb_sel",  32'(sel_l),  32'(e.sel_v));
        check("lsb_last", 32'(last_l), 32'(e.last_v));
      end
      beats_l++;
    end
  end

  // Monitor for the MSB-first instance.
  always @(negedge clk) begin
    if (rst_n && ov_m && rdy_m) begin
      beat_t e;
      if (q_m.size() == 0) begin
        check("msb_unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = q_m.pop_front();
        check("msb_out",  32'(out_m),  32'(e.bit_v));
        check("msb_sel",  32'(sel_m),  32'(e.sel_v));
        check("msb_last", 32'(last_m), 32'(e.last_v));
      end
      beats_m++;
    end
  end

  initial begin
    int valid_cnt;

    // Reset: load_ready must be held low while rst_n is low.
    repeat (3) tick();
    @(negedge clk);
    check("rst_load_ready_low", 32'(lr_l), 32'd0);
    check("rst_out_valid",      32'(ov_l), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_load_ready", 32'(lr_l),   32'd1);
    check("post_rst_busy",       32'(busy_l), 32'd0);
    check("post_rst_last",       32'(last_l), 32'd0);
    check("post_rst_sel",        32'(sel_l),  32'd0);
    check("post_rst_out",        32'(out_l),  32'd0);
    check("post_rst_msb_ready",  32'(lr_m),   32'd1);

    // Word 3F0A, LSB first; in is changed mid-word to prove isolation.
    tick();
    word = 16'h3F0A; lv_l = 1'b1;
    push_beats(16'h3F0A, 1'b0);
    beats_l = 0;
    tick();
    lv_l = 1'b0;
    word = 16'hC5C5;
    @(negedge clk);
    check("latency_first_valid", 32'(ov_l),  32'd1);
    check("latency_first_sel",   32'(sel_l), 32'd0);
    tick();
    word = 16'h0000;
    wait_idle(1'b0, "lsb_3f0a");
    check("lsb_3f0a_beats", 32'(beats_l), 32'd16);
    @(negedge clk);
    check("lsb_idle_load_ready", 32'(lr_l), 32'd1);
    check("lsb_idle_valid",      32'(ov_l), 32'd0);

    // Same word, MSB first: beats 0,0,1,1,1,1,1,1,0,0,0,0,1,0,1,0.
    tick();
    word = 16'h3F0A; lv_m = 1'b1;
    push_beats(16'h50FC, 1'b1);
    beats_m = 0;
    tick();
    lv_m = 1'b0;
    wait_idle(1'b1, "msb_3f0a");
    check("msb_3f0a_beats", 32'(beats_m), 32'd16);

    // Stall for 3 cycles at sel=6 on word A5C3 (bit 6 is 1).
    tick();
    word = 16'hA5C3; lv_l = 1'b1;
    push_beats(16'hA5C3, 1'b0);
    beats_l = 0;
    tick();
    lv_l = 1'b0;
    wait_sel(4'd6, "stall");
    rdy_l = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_sel",   32'(sel_l), 32'd6);
      check("stall_out",   32'(out_l), 32'd1);
      check("stall_valid", 32'(ov_l),  32'd1);
      tick();
    end
    rdy_l = 1'b1;
    wait_idle(1'b0, "stall");
    check("stall_beats", 32'(beats_l), 32'd16);

    // Back-to-back FFFF then 0001 with load_valid held.
    tick();
    word = 16'hFFFF; lv_l = 1'b1;
    push_beats(16'hFFFF, 1'b0);
    beats_l = 0;
    tick();
    word = 16'h0001;
    push_beats(16'h0001, 1'b0);
    valid_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (ov_l) valid_cnt++;
      if (i == 5)  check("b2b_mid_load_ready",  32'(lr_l), 32'd0);
      if (i == 15) check("b2b_last_load_ready", 32'(lr_l), 32'd1);
      tick();
      if (i == 15) lv_l = 1'b0;
    end
    check("b2b_contiguous_valid", 32'(valid_cnt), 32'd32);
    wait_idle(1'b0, "b2b");
    check("b2b_beats", 32'(beats_l), 32'd32);

    // Reset mid-word at sel=9, then a fresh 8000 word.
    tick();
    word = 16'h1234; lv_l = 1'b1;
    push_beats(16'h1234, 1'b0);
    tick();
    lv_l = 1'b0;
    wait_sel(4'd9, "midrst");
    rst_n = 1'b0;
    q_l.delete();
    @(negedge clk);
    check("midrst_load_ready_low", 32'(lr_l), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(ov_l),   32'd0);
    check("midrst_sel",   32'(sel_l),  32'd0);
    check("midrst_busy",  32'(busy_l), 32'd0);
    check("midrst_last",  32'(last_l), 32'd0);
    tick();
    word = 16'h8000; lv_l = 1'b1;
    push_beats(16'h8000, 1'b0);
    beats_l = 0;
    tick();
    lv_l = 1'b0;
    wait_idle(1'b0, "after_rst");
    check("after_rst_beats", 32'(beats_l), 32'd16);

    check("lsb_queue_drained", 32'(q_l.size()), 32'd0);
    check("msb_queue_drained", 32'(q_m.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux16_serializer.md
# mux16_serializer

Parallel-in, serial-out stage that sits directly upstream of, and embeds, the team's 16:1 bit-select mux. It accepts a 16-bit word on a valid/ready handshake and holds it in a shadow register. It then drives the mux select through all 16 positions, one bit per accepted output beat. The selected bit is presented on a valid/ready serial stream with a last-beat marker.

## Interface
- WIDTH, 16: word width; fixed at 16 to match the mux.
- SEL_W, 4: select width, log2(WIDTH).
- MSB_FIRST, 0: 0 sends bit 0 first and sel counts up; 1 sends bit 15 first and sel counts down.

- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in  input  16  parallel word; sampled on the load handshake.
- load_valid  input  1  upstream has a word on `in`.
- load_ready  output  1  block can accept a word this cycle.
- sel  output  SEL_W  current mux select, exported for debug and observation.
- out  output  1  current serial bit, equal to shadow[sel] through the mux.
- out_valid  output  1  `out` holds a valid beat.
- out_ready  input  1  downstream accepts the beat this cycle.
- last  output  1  current beat is the final bit of the word.
- busy  output  1  a word is being serialized (state SHIFT).

## Operation
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1, out_valid=0, last=0.
  - On load_valid: capture `in` into shadow, set sel to the start index (0, or 15 if MSB_FIRST), go to SHIFT.
- SHIFT:
  - out_valid=1; out = shadow[sel].
  - A beat fires on out_valid && out_ready. Each fired beat advances sel by +1 (or -1 if MSB_FIRST).
  - last=1 while sel is at the terminal index (15, or 0 if MSB_FIRST).
  - When the last beat fires:
    - If load_valid is also high, capture the new word, reset sel to the start index, and stay in SHIFT.
    - Otherwise return to IDLE.
- load_ready = IDLE || (SHIFT && last && out_ready). This path is combinational from out_ready and gives zero-bubble back-to-back words.
- Stall: while out_ready=0, sel, shadow and out hold stable, and out_valid stays 1.
- sel never wraps silently: the terminal index is always followed by a reload or by IDLE.
- load_valid is ignored in SHIFT except on the firing last beat.
- `in` is sampled only on the load handshake; later changes to `in` do not affect the word in flight.

## Timing
- Reset (rst_n low at an edge):
  - state=IDLE, sel=0, shadow=0.
  - out_valid=0, last=0, busy=0, out=0.
  - load_ready is forced 0 while rst_n is low and is 1 in the first cycle after release.
- Reset mid-word: abort immediately. The partial word is discarded, no further beats are produced, and last is never asserted for it.
- Latency: load accepted at edge N → first bit valid in cycle N+1.
- With out_ready held high:
  - 16 consecutive beats per word.
  - Throughput is 16 cycles per word when back-to-back.
  - Isolated words complete their last beat at edge N+16.
- out and sel change only on clock edges. No combinational path exists from `in` to `out`.

## Structure
- Package mux16_pkg holds:
  - constants WIDTH=16 and SEL_W=4;
  - START/TERM index helpers;
  - the state typedef {IDLE, SHIFT}.
- One sub-module: the existing mux16x1_structural, instantiated with in=shadow, sel=sel, out=out.
- Control FSM, sel counter and shadow register live in the top module. No further hierarchy.

## Test plan
- Reset then load 16'h3F0A, MSB_FIRST=0, out_ready=1 → out beats 0,1,0,1,0,0,0,0,1,1,1,1,1,1,0,0; sel 0..15; last only on beat 16; then IDLE with load_ready=1.
- Same word with MSB_FIRST=1 → beats 0,0,1,1,1,1,1,1,0,0,0,0,1,0,1,0; sel 15..0.
- Stall: drop out_ready for 3 cycles at sel=6 → sel, out and out_valid hold; resume → beat 7 follows; total still 16 beats.
- Back-to-back: load_valid held with 16'hFFFF then 16'h0001 → 32 contiguous beats with no idle cycle; load_ready pulses on the last beat of word 1.
- Reset mid-word: assert rst_n=0 at sel=9 → next cycle out_valid=0, sel=0, busy=0; a fresh load of 16'h8000 then streams correctly, with the single 1 on beat 16.
- Input isolation: change `in` during SHIFT → serialized bits still match the captured word.
